// File: rtl/ecg_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : ecg_sample_capture
// Purpose  : Captures one ECG sample (address, data, start-of-frame flag) on
//            each rising edge of the fetch unit's sample strobe. Samples are
//            buffered in a small FIFO and handed to a valid/ready consumer.
//            Optional macro ECG_MOVING_AVG_EN replaces the raw sample with a
//            4-tap moving average of the raw captured samples.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            sample_strobe       - fetch-unit sample clock (same domain)
//            address_in, data_in - current fetch address and ROM word
//            out_valid/out_ready - head-entry handshake
//            out_data, out_addr, out_sof - head entry contents
//            level               - FIFO occupancy, 0..DEPTH
//            overflow            - sticky "sample dropped" flag
// Revision : 1.0 - initial release
// ============================================================================
module ecg_sample_capture #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_strobe,
  input  logic [ADDR_W-1:0]        address_in,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     out_sof,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [PTR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]  rd_ptr_q, rd_ptr_d;
  logic            strobe_q;
  logic            overflow_q, overflow_d;

  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic              mem_sof_q  [DEPTH];

  logic              capture;
  logic              pop;
  logic              push;
  logic              full;
  logic [DATA_W-1:0] store_val;
  logic [PTR_W-1:0]  rd_idx;
  logic [PTR_W-1:0]  wr_idx;

  assign capture = sample_strobe & ~strobe_q;
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == C_FULL);
  assign pop     = out_valid & out_ready;
  // At full a simultaneous pop frees the slot the new sample goes into.
  assign push    = capture & (~full | pop);
  assign rd_idx  = rd_ptr_q[PTR_W-1:0];
  assign wr_idx  = wr_ptr_q[PTR_W-1:0];

`ifdef ECG_MOVING_AVG_EN
  // Last three raw captures, newest first. Dropped samples still shift in.
  logic [DATA_W-1:0] hist_q [3];
  logic [DATA_W+1:0] avg_sum;

  assign avg_sum   = (DATA_W+2)'(data_in) + (DATA_W+2)'(hist_q[0])
                   + (DATA_W+2)'(hist_q[1]) + (DATA_W+2)'(hist_q[2]);
  assign store_val = DATA_W'(avg_sum >> 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q[0] <= '0;
      hist_q[1] <= '0;
      hist_q[2] <= '0;
    end else if (capture) begin
      hist_q[0] <= data_in;
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
    end
  end
`else
  assign store_val = data_in;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (capture && !push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Starting high means a strobe already asserted at release is ignored.
      strobe_q   <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      strobe_q   <= sample_strobe;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_idx] <= store_val;
      mem_addr_q[wr_idx] <= address_in;
      mem_sof_q[wr_idx]  <= (address_in == '0);
    end
  end

  assign out_valid = (level != '0);
  assign overflow  = overflow_q;
  assign out_data  = out_valid ? mem_data_q[rd_idx] : '0;
  assign out_addr  = out_valid ? mem_addr_q[rd_idx] : '0;
  assign out_sof   = out_valid ? mem_sof_q[rd_idx]  : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ecg_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecg_sample_capture
// Purpose  : Scoreboard bench for ecg_sample_capture. A queue-based reference
//            model predicts accepted entries, occupancy and overflow; a
//            negedge monitor compares the DUT head entry on every handshake.
//            Honours ECG_MOVING_AVG_EN in its reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecg_sample_capture;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_strobe = 1'b0;
  logic [ADDR_W-1:0] address_in = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_sof;
  logic [2:0]        level;
  logic              overflow;

  ecg_sample_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe),
    .address_in(address_in), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_sof(out_sof), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int sof;
  } entry_t;

  // Reference model state
  entry_t exp_q[$];
  int     hist[$];
  int     mcount;
  int     movf;
  int     prev_strobe;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    hist = '{0, 0, 0};
    mcount = 0;
    movf = 0;
    prev_strobe = 1;
  endtask

  // Applies the rules for one clock edge given the inputs that were held
  // during the preceding cycle.
  task automatic model_edge(input int s, input int a, input int d, input int r);
    int pop;
    int cap;
    int val;
    entry_t e;
    if (!rst_n) begin
      prev_strobe = 1;
      return;
    end
    pop = (r != 0 && mcount > 0) ? 1 : 0;
    cap = (s != 0 && prev_strobe == 0) ? 1 : 0;
    prev_strobe = s;
    if (cap != 0) begin
`ifdef ECG_MOVING_AVG_EN
      val = ((d + hist[0] + hist[1] + hist[2]) / 4) % (1 << DATA_W);
      hist.push_front(d);
      void'(hist.pop_back());
`else
      val = d;
`endif
      if (mcount < DEPTH || pop != 0) begin
        e.addr = a;
        e.data = val;
        e.sof  = (a == 0) ? 1 : 0;
        exp_q.push_back(e);
        mcount++;
      end else begin
        movf = 1;
      end
    end
    mcount -= pop;
  endtask

  task automatic step(input int s, input int a, input int d, input int r);
    sample_strobe = s[0];
    address_in    = a[ADDR_W-1:0];
    data_in       = d[DATA_W-1:0];
    out_ready     = r[0];
    @(posedge clk);
    #2;
    model_edge(s, a, d, r);
  endtask

  // Monitor: compare model state each cycle and head contents on each pop.
  always @(negedge clk) begin
    chk("level", int'(level), mcount);
    chk("out_valid", int'(out_valid), (mcount > 0) ? 1 : 0);
    chk("overflow", int'(overflow), movf);
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        chk("out_addr", int'(out_addr), exp_q[0].addr);
        chk("out_data", int'(out_data), exp_q[0].data);
        chk("out_sof", int'(out_sof), exp_q[0].sof);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_addr", int'(out_addr), 0);
    chk("rst_sof", int'(out_sof), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 3; i++) step(0, 0, 0, 1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    model_reset();
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // Single strobe, address 0, ready high.
    step(1, 'h000, 'h123, 1);
    chk("single_valid", int'(out_valid), 1);
    chk("single_sof", int'(out_sof), 1);
    step(0, 0, 0, 1);
    chk("single_after", int'(out_valid), 0);
    drain();

    // Five strobes with ready low: fifth is dropped.
    for (int i = 1; i <= 5; i++) begin
      step(1, 'h010 + i, 'h100 * i, 0);
      step(0, 0, 0, 0);
    end
    chk("five_level", int'(level), DEPTH);
    chk("five_ovf", int'(overflow), 1);
    drain();

    // Held strobe, then reset with two entries stored while strobe is high.
    step(1, 'h005, 'h055, 0);
    step(1, 'h005, 'h055, 0);
    step(1, 'h005, 'h055, 0);
    chk("held_level", int'(level), 1);
    step(0, 0, 0, 0);
    step(1, 'h006, 'h066, 0);
    chk("two_level", int'(level), 2);
    do_reset();
    step(1, 'h007, 'h077, 0);
    step(1, 'h007, 'h077, 0);
    rst_n = 1'b1;
    step(1, 'h007, 'h077, 0);
    step(1, 'h007, 'h077, 0);
    chk("no_cap_after_rst", int'(level), 0);
    step(0, 0, 0, 0);

    // Fill, then capture and pop on the same edge at full.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 'h020 + i, 'h200 + i, 0);
      step(0, 0, 0, 0);
    end
    step(1, 'h0AA, 'h0BB, 1);
    chk("full_pop_level", int'(level), DEPTH);
    chk("full_pop_ovf", int'(overflow), 0);
    drain();

    // Moving-average reference sequence from a clean history.
    do_reset();
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1, 'h030 + i, 'h100 * i, 1);
      step(0, 0, 0, 1);
    end
    // Address wrap 0xFFF -> 0x000, and capture+pop at level 1.
    step(1, 'hFFF, 'h0F0, 0);
    step(0, 0, 0, 0);
    step(1, 'h000, 'h00F, 1);
    chk("lvl1_valid", int'(out_valid), 1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int s, a, d, r, sel;
      s = ($urandom_range(0, 2) == 0) ? 1 : 0;
      r = ($urandom_range(0, 3) != 0) ? 1 : 0;
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? 0 : (sel == 1) ? 'hFFF : int'($urandom_range(0, 'hFFF));
      d = int'($urandom_range(0, 'hFFF));
      step(s, a, d, r);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ecg_sample_capture.md
ECG_SAMPLE_CAPTURE -- requirements
Module: ecg_sample_capture

Interface
REQ-001 Parameter DATA_W, default 12, ECG sample width.
REQ-002 Parameter ADDR_W, default 12, fetch address width.
REQ-003 Parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sample_strobe  input  1  fetch-unit sample clock output, same clk domain, no synchronizer.
REQ-007 address_in  input  ADDR_W  current fetch address.
REQ-008 data_in  input  DATA_W  sample-ROM word at address_in.
REQ-009 out_valid  output  1  FIFO head entry present.
REQ-010 out_ready  input  1  consumer accepts head entry.
REQ-011 out_data  output  DATA_W  head sample (raw or averaged).
REQ-012 out_addr  output  ADDR_W  address captured with head sample.
REQ-013 out_sof  output  1  head entry is frame start (captured address == 0).
REQ-014 level  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-015 overflow  output  1  sticky flag, sample dropped because FIFO was full.

Function
REQ-016 Register strobe_q <= sample_strobe each cycle; capture event = sample_strobe & ~strobe_q (rising edge only).
REQ-017 On a capture event, write {address_in, data_in or average, address_in==0} into the FIFO tail in that cycle.
REQ-018 Latency: out_valid = 1 on the cycle after the capture cycle when the FIFO was empty.
REQ-019 Pop when out_valid & out_ready; head advances on the next edge.
REQ-020 out_data, out_addr and out_sof are stable while out_valid=1 and out_ready=0; they are don't-care while out_valid=0.
REQ-021 Capture with FIFO full and no pop: drop the sample, set overflow=1, leave FIFO contents unchanged.
REQ-022 Capture and pop in the same cycle at full: both happen; level stays DEPTH; no overflow.
REQ-023 Capture and pop in the same cycle at level 1: the new entry becomes head; out_valid stays 1.
REQ-024 Pop with FIFO empty: ignored.
REQ-025 Read and write pointers wrap modulo DEPTH; level = write count minus read count, range 0..DEPTH.
REQ-026 Address wrap 0xFFF->0x000 requires no special handling beyond out_sof=1 for the address-0 entry.
REQ-027 overflow stays at 1 until reset.
REQ-028 A strobe held high for multiple cycles yields exactly one capture.

Reset
REQ-029 While rst_n=0: out_valid=0, level=0, overflow=0, out_sof=0, out_data=0, out_addr=0, pointers=0, average history=0.
REQ-030 strobe_q resets to 1, so a strobe already high at reset release does not capture.
REQ-031 Reset asserted mid-operation discards all stored entries immediately (asynchronous).

Configuration
REQ-032 Macro ECG_MOVING_AVG_EN selects the stored sample value.
REQ-033 Macro defined: stored value = (sum of the current capture and the previous 3 captured raw samples) >> 2.
- Sum width DATA_W+2, truncated to DATA_W after the shift.
- History is zero after reset, so the first 3 results include zeros.
- Dropped (overflow) samples still enter the history.
REQ-034 Macro undefined: stored value = data_in; no history registers exist.

Verification
REQ-035 Single strobe pulse, address 0x000, data 0x123, out_ready=1 -> one cycle later out_valid=1, out_addr=0x000, out_data=0x123 (raw), out_sof=1; out_valid=0 the following cycle.
REQ-036 5 strobes with out_ready=0, DEPTH=4 -> level=4, overflow=1, entries 1..4 emitted in order after out_ready=1, 5th sample absent.
REQ-037 FIFO full, strobe and out_ready=1 in the same cycle -> level stays 4, overflow stays 0, new entry is last out.
REQ-038 ECG_MOVING_AVG_EN defined, samples 0x100, 0x200, 0x300, 0x400 -> out_data 0x040, 0x0C0, 0x180, 0x280.
REQ-039 Strobe held high 3 cycles; rst_n pulsed low while 2 entries are stored -> exactly 1 capture; after reset level=0, out_valid=0, overflow=0, and no capture while the strobe is still high.
